// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO (first-word-fall-through) fed by the UART RX done/byte strobe.
// Define UART_RX_FIFO_AF_EN to add the AF_THRESH parameter and the registered o_Almost_Full output.
module uart_rx_fifo #(
    parameter int unsigned DEPTH     = 16
`ifdef UART_RX_FIFO_AF_EN
    , parameter int unsigned AF_THRESH = 12
`endif
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_Rx_Done,
    input  logic [7:0]                   i_Rx_Byte,
    input  logic                         i_Rd_En,
    input  logic                         i_Clr_Overflow,
    output logic [7:0]                   o_Rd_Byte,
    output logic                         o_Empty,
    output logic                         o_Full,
    output logic [$clog2(DEPTH):0]       o_Count,
    output logic                         o_Overflow
`ifdef UART_RX_FIFO_AF_EN
    , output logic                       o_Almost_Full
`endif
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              rx_done_q;
    logic              armed;
    logic              push;
    logic              pop;
    logic              wr_en;
    logic              drop;

    // armed stays low for the first cycle after reset so a level already high at release is not a push
    always_comb begin
        push       = i_Rx_Done & ~rx_done_q & armed;
        pop        = i_Rd_En & ~o_Empty;
        wr_en      = push & (~o_Full | pop);
        drop       = push & o_Full & ~pop;
        count_next = count;
        case ({wr_en, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Storage is not reset; a full-and-pop write lands on the slot being vacated
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= i_Rx_Byte;
        end
    end

    assign o_Rd_Byte = mem[rd_ptr];
    assign o_Count   = count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rx_done_q  <= 1'b0;
            armed      <= 1'b0;
            o_Empty    <= 1'b1;
            o_Full     <= 1'b0;
            o_Overflow <= 1'b0;
        end else begin
            rx_done_q <= i_Rx_Done;
            armed     <= 1'b1;
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            count   <= count_next;
            o_Empty <= (count_next == '0);
            o_Full  <= (count_next == CNT_W'(DEPTH));
            // a new drop outranks a simultaneous clear
            if (drop) begin
                o_Overflow <= 1'b1;
            end else if (i_Clr_Overflow) begin
                o_Overflow <= 1'b0;
            end
        end
    end

`ifdef UART_RX_FIFO_AF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_Almost_Full <= 1'b0;
        end else begin
            o_Almost_Full <= (count_next >= CNT_W'(AF_THRESH));
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: vector table for single-entry behaviour,
// hand-written sequences for fill/overflow, full push+pop, pointer wrap and reset.
module tb_uart_rx_fifo;
    localparam int unsigned DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx_done;
    logic [7:0] rx_byte;
    logic       rd_en;
    logic       clr_ovf;
    logic [7:0] rd_byte;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       ovf;
`ifdef UART_RX_FIFO_AF_EN
    logic       af;
`endif

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_Rx_Done      (rx_done),
        .i_Rx_Byte      (rx_byte),
        .i_Rd_En        (rd_en),
        .i_Clr_Overflow (clr_ovf),
        .o_Rd_Byte      (rd_byte),
        .o_Empty        (empty),
        .o_Full         (full),
        .o_Count        (count),
        .o_Overflow     (ovf)
`ifdef UART_RX_FIFO_AF_EN
        , .o_Almost_Full(af)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic       done;
        logic [7:0] din;
        logic       rd;
        logic       clr;
        logic       e_empty;
        logic       e_full;
        logic [4:0] e_count;
        logic       e_ovf;
        logic       chk_byte;
        logic [7:0] e_byte;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // drive inputs, advance one clock, leave time 1 unit past the edge for sampling
    task automatic cyc(input logic d, input logic [7:0] b, input logic r, input logic c);
        rx_done = d;
        rx_byte = b;
        rd_en   = r;
        clr_ovf = c;
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        cyc(1'b1, b, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        rx_done = 1'b0; rx_byte = 8'h00; rd_en = 1'b0; clr_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    vec_t vt[15];
    logic [7:0] q[$];

    initial begin
        // done, din, rd, clr | empty, full, count, ovf, chk_byte, byte
        vt[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 8'hA5};
        vt[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00};
        vt[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00};
        vt[3]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 8'h3C};
        vt[4]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 8'h3C};
        vt[5]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 8'h3C};
        vt[6]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 8'h3C};
        vt[7]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 8'h3C};
        vt[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 8'h3C};
        vt[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00};
        vt[10] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 8'h5A};
        vt[11] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 8'h5A};
        vt[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 8'h5A};
        vt[13] = '{1'b1, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 8'hC3};
        vt[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00};

        do_reset();
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_full", 32'(full), 32'd0);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
`ifdef UART_RX_FIFO_AF_EN
        chk("reset_af", 32'(af), 32'd0);
`endif

        for (int i = 0; i < 15; i++) begin
            cyc(vt[i].done, vt[i].din, vt[i].rd, vt[i].clr);
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vt[i].e_empty));
            chk($sformatf("vec%0d_full", i), 32'(full), 32'(vt[i].e_full));
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].e_count));
            chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vt[i].e_ovf));
            if (vt[i].chk_byte) begin
                chk($sformatf("vec%0d_byte", i), 32'(rd_byte), 32'(vt[i].e_byte));
            end
        end

        // fill to full, then one push too many
        for (int i = 0; i < 16; i++) begin
            push_byte(8'(i));
            chk("fill_count", 32'(count), 32'(i + 1));
`ifdef UART_RX_FIFO_AF_EN
            chk("fill_af", 32'(af), 32'(i + 1 >= 12));
`endif
        end
        chk("fill_full", 32'(full), 32'd1);
        cyc(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("drop_ovf", 32'(ovf), 32'd1);
        chk("drop_count", 32'(count), 32'd16);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            chk("drain_byte", 32'(rd_byte), 32'(i));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_count", 32'(count), 32'(15 - i));
`ifdef UART_RX_FIFO_AF_EN
            chk("drain_af", 32'(af), 32'(15 - i >= 12));
`endif
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("ovf_sticky", 32'(ovf), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clear", 32'(ovf), 32'd0);

        // full with simultaneous push and pop: push accepted, no overflow
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        chk("pp_head", 32'(rd_byte), 32'h00);
        cyc(1'b1, 8'h77, 1'b1, 1'b0);
        chk("pp_count", 32'(count), 32'd16);
        chk("pp_full", 32'(full), 32'd1);
        chk("pp_ovf", 32'(ovf), 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        // drop and clear in the same cycle: drop wins
        cyc(1'b1, 8'hEE, 1'b0, 1'b1);
        chk("setwins_ovf", 32'(ovf), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_ovf", 32'(ovf), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            chk("pp_drain", 32'(rd_byte), (i == 16) ? 32'h77 : 32'(i));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("pp_empty", 32'(empty), 32'd1);

        // 40 bytes interleaved at low occupancy, wrapping the pointers
        q.delete();
        for (int k = 0; k < 80 || q.size() > 0; k++) begin
            logic d;
            logic r;
            logic [7:0] b;
            d = (k < 80) && (k % 2 == 0);
            b = 8'((k / 2) * 37 + 11);
            r = (q.size() >= 2) || (k >= 80 && q.size() > 0);
            if (r) begin
                chk("wrap_byte", 32'(rd_byte), 32'(q[0]));
                void'(q.pop_front());
            end
            if (d) q.push_back(b);
            cyc(d, b, r, 1'b0);
            chk("wrap_count", 32'(count), 32'(q.size()));
        end
        chk("wrap_empty", 32'(empty), 32'd1);

        // reset mid-stream empties immediately, without a clock edge
        for (int i = 0; i < 5; i++) push_byte(8'(8'hB0 + i));
        chk("pre_rst_count", 32'(count), 32'd5);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_count", 32'(count), 32'd0);
        // done already high at reset release must not push
        rx_done = 1'b1;
        rx_byte = 8'h99;
        @(posedge clk);
        #1 reset_n = 1'b1;
        cyc(1'b1, 8'h99, 1'b0, 1'b0);
        cyc(1'b1, 8'h99, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("rel_high_count", 32'(count), 32'd0);
        chk("rel_high_empty", 32'(empty), 32'd1);
        push_byte(8'h42);
        chk("post_rst_byte", 32'(rd_byte), 32'h42);
        chk("post_rst_count", 32'(count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
